fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter with call/return stack, jump redirect
// and a registered ALU zero flag.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_inc,
    input  logic                     enable_jal,
    input  logic                     s_jal,
    input  logic                     hold,
    input  logic [15:0]              pm_data,
    input  logic                     alu_z,
    input  logic                     flag_we,
    output logic [PC_W-1:0]          pm_addr,
    output logic [5:0]               opcode,
    output logic                     z,
    output logic                     stk_ovf,
    output logic                     stk_unf,
    output logic [$clog2(DEPTH):0]   stk_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CALL,
        OP_RET,
        OP_JUMP,
        OP_INC
    } op_t;

    op_t             w_op;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_tos;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] r_stk [DEPTH];
    logic [AW-1:0]   r_sp;
    logic [AW-1:0]   w_sp_top;
    logic [AW:0]     r_cnt;
    logic            w_full;
    logic            w_empty;
    logic            r_z;
    logic            r_ovf;
    logic            r_unf;

    assign w_pc_inc = r_pc + 1'b1;
    assign w_target = pm_data[PC_W-1:0];
    // r_sp points at the next free slot; the top entry sits just below it.
    assign w_sp_top = r_sp - 1'b1;
    assign w_tos    = r_stk[w_sp_top];
    assign w_full   = (r_cnt == CNT_FULL);
    assign w_empty  = (r_cnt == '0);

    always_comb begin
        w_op = OP_INC;
        if (hold)
            w_op = OP_HOLD;
        else if (enable_jal)
            w_op = OP_CALL;
        else if (s_jal)
            w_op = OP_RET;
        else if (!s_inc)
            w_op = OP_JUMP;
    end

    always_comb begin
        w_pc_next = r_pc;
        case (w_op)
            OP_HOLD: w_pc_next = r_pc;
            OP_CALL: w_pc_next = w_target;
            OP_RET:  w_pc_next = w_empty ? w_pc_inc : w_tos;
            OP_JUMP: w_pc_next = w_target;
            OP_INC:  w_pc_next = w_pc_inc;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_sp  <= '0;
            r_cnt <= '0;
            r_z   <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (!hold && flag_we)
                r_z <= alu_z;
            // A push on a full stack wraps r_sp onto the oldest entry.
            if (w_op == OP_CALL) begin
                r_sp <= r_sp + 1'b1;
                if (w_full)
                    r_ovf <= 1'b1;
                else
                    r_cnt <= r_cnt + 1'b1;
            end else if (w_op == OP_RET) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_sp  <= w_sp_top;
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    // Stack storage carries no reset; entries are unreadable while empty.
    always_ff @(posedge clk) begin
        if (!reset && w_op == OP_CALL)
            r_stk[r_sp] <= w_pc_inc;
    end

    assign pm_addr = r_pc;
    assign opcode  = pm_data[15:10];
    assign z       = r_z;
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;
    assign stk_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset, s_inc, enable_jal, s_jal, hold;
    logic [15:0]       pm_data;
    logic              alu_z, flag_we;
    logic [PC_W-1:0]   pm_addr;
    logic [5:0]        opcode;
    logic              z, stk_ovf, stk_unf;
    logic [2:0]        stk_cnt;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state
    logic [PC_W-1:0] m_pc = '0;
    logic [PC_W-1:0] m_stk[$];
    logic            m_z = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    fetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_inc(s_inc), .enable_jal(enable_jal),
        .s_jal(s_jal), .hold(hold), .pm_data(pm_data), .alu_z(alu_z),
        .flag_we(flag_we), .pm_addr(pm_addr), .opcode(opcode), .z(z),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf), .stk_cnt(stk_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic rst, hld, ej, sj, si, fwe, az,
                              input logic [15:0] data);
        logic [PC_W-1:0] nxt;
        nxt = m_pc + 1'b1;
        if (rst) begin
            m_pc = '0; m_stk.delete(); m_z = 0; m_ovf = 0; m_unf = 0;
        end else if (!hld) begin
            if (fwe) m_z = az;
            if (ej) begin
                m_stk.push_back(nxt);
                if (m_stk.size() > DEPTH) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1;
                end
                m_pc = data[PC_W-1:0];
            end else if (sj) begin
                if (m_stk.size() == 0) begin
                    m_unf = 1;
                    m_pc = nxt;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (!si) begin
                m_pc = data[PC_W-1:0];
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic cycle(input logic rst, hld, ej, sj, si, fwe, az,
                         input logic [15:0] data);
        reset = rst; hold = hld; enable_jal = ej; s_jal = sj; s_inc = si;
        flag_we = fwe; alu_z = az; pm_data = data;
        @(posedge clk);
        model_step(rst, hld, ej, sj, si, fwe, az, data);
        #1;
    endtask

    function automatic logic [15:0] rnd_hi(input logic [PC_W-1:0] tgt);
        logic [15:0] w;
        w = 16'($urandom_range(0, 65535));
        w[PC_W-1:0] = tgt;
        return w;
    endfunction

    task automatic do_inc();
        cycle(0, 0, 0, 0, 1, 0, 0, 16'($urandom));
    endtask
    task automatic do_jump(input logic [PC_W-1:0] t);
        cycle(0, 0, 0, 0, 0, 0, 0, rnd_hi(t));
    endtask
    task automatic do_call(input logic [PC_W-1:0] t);
        cycle(0, 0, 1, 0, 1, 0, 0, rnd_hi(t));
    endtask
    task automatic do_ret();
        cycle(0, 0, 0, 1, 1, 0, 0, 16'($urandom));
    endtask
    task automatic do_reset();
        cycle(1, 0, 0, 0, 1, 0, 0, 16'($urandom));
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 0, 1, 1, 16'hFFFF);
        n_chk++; if (pm_addr !== 10'd0) begin n_err++; $display("FAIL reset_pc got=%0d exp=0", pm_addr); end
        n_chk++; if (stk_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", stk_cnt); end
        n_chk++; if ({z, stk_ovf, stk_unf} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {z, stk_ovf, stk_unf}); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            do_inc();
            n_chk++; if (pm_addr !== 10'(i)) begin n_err++; $display("FAIL seq_pc got=%0d exp=%0d", pm_addr, i); end
        end
        do_jump(10'd1023);
        n_chk++; if (pm_addr !== 10'd1023) begin n_err++; $display("FAIL jump_pc got=%0d exp=1023", pm_addr); end
        do_inc();
        n_chk++; if (pm_addr !== 10'd0) begin n_err++; $display("FAIL wrap_pc got=%0d exp=0", pm_addr); end
        n_chk++; if (stk_cnt !== 3'd0) begin n_err++; $display("FAIL jump_cnt got=%0d exp=0", stk_cnt); end
    endtask

    task automatic test_opcode();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            pm_data = w;
            #1;
            n_chk++; if (opcode !== w[15:10]) begin n_err++; $display("FAIL opcode got=%h exp=%h", opcode, w[15:10]); end
        end
    endtask

    task automatic test_call_return();
        do_reset();
        do_jump(10'd5);
        do_call(10'h040);
        n_chk++; if (pm_addr !== 10'h040) begin n_err++; $display("FAIL call_pc got=%h exp=040", pm_addr); end
        n_chk++; if (stk_cnt !== 3'd1) begin n_err++; $display("FAIL call_cnt got=%0d exp=1", stk_cnt); end
        do_inc();
        do_inc();
        // Both call and return requested: call wins.
        cycle(0, 0, 1, 1, 1, 0, 0, rnd_hi(10'h080));
        n_chk++; if (pm_addr !== 10'h080 || stk_cnt !== 3'd2) begin n_err++; $display("FAIL call_over_ret got=%h/%0d exp=080/2", pm_addr, stk_cnt); end
        do_ret();
        n_chk++; if (pm_addr !== 10'h043) begin n_err++; $display("FAIL ret_inner got=%h exp=043", pm_addr); end
        do_ret();
        n_chk++; if (pm_addr !== 10'd6) begin n_err++; $display("FAIL ret_pc got=%0d exp=6", pm_addr); end
        n_chk++; if (stk_cnt !== 3'd0 || stk_unf !== 1'b0) begin n_err++; $display("FAIL ret_cnt got=%0d/%b exp=0/0", stk_cnt, stk_unf); end
    endtask

    task automatic test_overflow();
        do_reset();
        do_jump(10'd1);
        for (int i = 1; i <= 5; i++)
            do_call(i == 5 ? 10'h100 : 10'(i + 1));
        n_chk++; if (stk_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", stk_ovf); end
        n_chk++; if (stk_cnt !== 3'd4) begin n_err++; $display("FAIL ovf_cnt got=%0d exp=4", stk_cnt); end
        for (int i = 0; i < 4; i++) begin
            do_ret();
            n_chk++; if (pm_addr !== 10'(6 - i)) begin n_err++; $display("FAIL ovf_ret got=%0d exp=%0d", pm_addr, 6 - i); end
        end
        n_chk++; if (stk_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", stk_ovf); end
    endtask

    task automatic test_underflow();
        do_jump(10'd10);
        do_ret();
        n_chk++; if (pm_addr !== 10'd11) begin n_err++; $display("FAIL unf_pc got=%0d exp=11", pm_addr); end
        n_chk++; if (stk_unf !== 1'b1 || stk_cnt !== 3'd0) begin n_err++; $display("FAIL unf_flag got=%b/%0d exp=1/0", stk_unf, stk_cnt); end
        do_inc();
        n_chk++; if (stk_unf !== 1'b1) begin n_err++; $display("FAIL unf_sticky got=%b exp=1", stk_unf); end
    endtask

    task automatic test_flag_hold();
        logic [PC_W-1:0] exp_pc;
        do_reset();
        do_jump(10'h020);
        do_call(10'h030);
        cycle(0, 0, 0, 0, 1, 1, 1, 16'($urandom));
        n_chk++; if (z !== 1'b1) begin n_err++; $display("FAIL z_set got=%b exp=1", z); end
        cycle(0, 0, 0, 0, 1, 0, 0, 16'($urandom));
        n_chk++; if (z !== 1'b1) begin n_err++; $display("FAIL z_keep got=%b exp=1", z); end
        exp_pc = 10'h032;
        cycle(0, 1, 1, 0, 0, 1, 0, rnd_hi(10'h3AA));
        n_chk++; if (pm_addr !== exp_pc) begin n_err++; $display("FAIL hold_pc got=%h exp=%h", pm_addr, exp_pc); end
        n_chk++; if (stk_cnt !== 3'd1 || z !== 1'b1) begin n_err++; $display("FAIL hold_state got=%0d/%b exp=1/1", stk_cnt, z); end
        do_ret();
        n_chk++; if (pm_addr !== 10'h021) begin n_err++; $display("FAIL hold_stack got=%h exp=021", pm_addr); end
    endtask

    task automatic test_reset_priority();
        do_jump(10'h055);
        do_call(10'h066);
        do_ret(); do_ret();
        cycle(0, 0, 0, 0, 1, 1, 1, 16'($urandom));
        cycle(1, 1, 1, 1, 0, 1, 1, rnd_hi(10'h123));
        n_chk++; if (pm_addr !== 10'd0 || stk_cnt !== 3'd0) begin n_err++; $display("FAIL rstpri_pc got=%h/%0d exp=0/0", pm_addr, stk_cnt); end
        n_chk++; if ({z, stk_ovf, stk_unf} !== 3'b000) begin n_err++; $display("FAIL rstpri_flags got=%b exp=000", {z, stk_ovf, stk_unf}); end
        do_ret();
        n_chk++; if (pm_addr !== 10'd1 || stk_unf !== 1'b1) begin n_err++; $display("FAIL rstpri_empty got=%0d/%b exp=1/1", pm_addr, stk_unf); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic rst, hld, ej, sj, si, fwe, az;
            logic [15:0] data;
            rst  = ($urandom_range(0, 59) == 0);
            hld  = ($urandom_range(0, 5) == 0);
            ej   = ($urandom_range(0, 3) == 0);
            sj   = ($urandom_range(0, 3) == 0);
            si   = ($urandom_range(0, 3) != 0);
            fwe  = 1'($urandom);
            az   = 1'($urandom);
            data = 16'($urandom);
            cycle(rst, hld, ej, sj, si, fwe, az, data);
            n_chk++;
            if (pm_addr !== m_pc || stk_cnt !== 3'(m_stk.size()) ||
                z !== m_z || stk_ovf !== m_ovf || stk_unf !== m_unf) begin
                n_err++;
                $display("FAIL random[%0d] got pc=%h cnt=%0d z=%b ovf=%b unf=%b exp pc=%h cnt=%0d z=%b ovf=%b unf=%b",
                         i, pm_addr, stk_cnt, z, stk_ovf, stk_unf,
                         m_pc, m_stk.size(), m_z, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        reset = 1; hold = 0; enable_jal = 0; s_jal = 0; s_inc = 1;
        flag_we = 0; alu_z = 0; pm_data = '0;
        test_reset();
        test_sequential();
        test_opcode();
        test_call_return();
        test_overflow();
        test_underflow();
        test_flag_hold();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
